// File: rtl/dmem_responder.sv
// Byte-enabled data-memory responder (one request in flight); DMEM_WAIT_EN adds WAIT_CYCLES wait states.
// Response 1 + wait cycles after accept; RESP holds until resp_ready, and req_ready stays low until then.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          req_err;
    logic          acc_fire;
    logic          acc_we;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;

`ifdef DMEM_WAIT_EN
    localparam int EFF_WAIT = WAIT_CYCLES;
    logic [3:0]    wait_cnt;
    logic          cap_we;
    logic          cap_err;
    logic [AW-1:0] cap_idx;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_be;
`else
    localparam int EFF_WAIT = 0;
`endif

    assign accept  = req_valid && req_ready;
    assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

    // The access either happens straight off the request (no wait) or off the captured copy at the end of WAIT.
    always_comb begin
        acc_fire  = accept && (EFF_WAIT == 0);
        acc_we    = req_we;
        acc_err   = req_err;
        acc_idx   = req_addr[AW+1:2];
        acc_wdata = req_wdata;
        acc_be    = req_be;
`ifdef DMEM_WAIT_EN
        if (state == WAIT) begin
            acc_fire  = (wait_cnt == 4'd0);
            acc_we    = cap_we;
            acc_err   = cap_err;
            acc_idx   = cap_idx;
            acc_wdata = cap_wdata;
            acc_be    = cap_be;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (acc_fire && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
`ifdef DMEM_WAIT_EN
            wait_cnt   <= 4'd0;
            cap_we     <= 1'b0;
            cap_err    <= 1'b0;
            cap_idx    <= '0;
            cap_wdata  <= 32'd0;
            cap_be     <= 4'd0;
`endif
        end else begin
            if (acc_fire) begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
`ifdef DMEM_WAIT_EN
                        if (EFF_WAIT > 0) begin
                            state     <= WAIT;
                            wait_cnt  <= 4'(WAIT_CYCLES - 1);
                            cap_we    <= req_we;
                            cap_err   <= req_err;
                            cap_idx   <= req_addr[AW+1:2];
                            cap_wdata <= req_wdata;
                            cap_be    <= req_be;
                        end
`endif
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
`ifdef DMEM_WAIT_EN
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
